// File: rtl/wb_pipe_master_if.sv
// Request/response port plus Wishbone B4 pipelined bus signals for wb_pipe_master.
// The master modport is the initiator side; the slave modport is the environment (requester + Wishbone slave).
interface wb_pipe_if #(
    parameter int AW = 24,
    parameter int DW = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic [DW/8-1:0]   req_byteenable;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [AW-1:0]     wb_adr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic [DW-1:0]     wb_dat_i;
    logic              wb_ack_i;
    logic              wb_stall_i;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_byteenable,
        input  wb_dat_i, wb_ack_i, wb_stall_i,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_byteenable,
        output wb_dat_i, wb_ack_i, wb_stall_i,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
endinterface

// File: rtl/wb_pipe_master.sv
// Wishbone B4 pipelined master: valid/ready requests become STB beats, one response per counted ACK.
// Define WB_TIMEOUT_EN to build the ACK watchdog that aborts the cycle after TIMEOUT idle cycles.
module wb_pipe_master #(
    parameter int AW              = 24,
    parameter int DW              = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic     clk,
    input  logic     rst_n,
    wb_pipe_if.master bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    if (AW < 1 || DW < 8 || (DW % 8) != 0 || MAX_OUTSTANDING < 1 || TIMEOUT < 1) begin : g_param_check
        $error("wb_pipe_master: illegal parameter combination");
    end

    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nx;
    logic          stb_nx;
    logic          issue;
    logic          ack_cnt;
    logic          accept;
    logic          dir_ok;
    logic          room_ok;
    logic          abort;
    logic          rdy_en;

    assign issue   = bus.wb_stb_o & ~bus.wb_stall_i;
    assign ack_cnt = bus.wb_ack_i & (outstanding != '0) & ~abort;
    assign dir_ok  = ((outstanding == '0) & ~bus.wb_stb_o) | (bus.req_write == bus.wb_we_o);
    assign room_ok = (({1'b0, outstanding} + (CW+1)'(bus.wb_stb_o)) < (CW+1)'(MAX_OUTSTANDING));

    // Same-cycle ACKs deliberately do not free a slot; rdy_en keeps ready low while in reset.
    assign bus.req_ready = rdy_en & (~bus.wb_stb_o | ~bus.wb_stall_i) & room_ok & dir_ok & ~abort;
    assign accept        = bus.req_valid & bus.req_ready;

`ifdef WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_cnt;

    assign abort = (wd_cnt == TW'(TIMEOUT)) & (outstanding != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            bus.rsp_err <= 1'b0;
        end else begin
            bus.rsp_err <= abort;
            if (abort || bus.wb_ack_i || outstanding == '0)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + TW'(1);
        end
    end
`else
    assign abort       = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        outstanding_nx = outstanding;
        stb_nx         = bus.wb_stb_o;
        if (abort) begin
            outstanding_nx = '0;
            stb_nx         = 1'b0;
        end else begin
            if (issue && !ack_cnt)
                outstanding_nx = outstanding + CW'(1);
            else if (!issue && ack_cnt)
                outstanding_nx = outstanding - CW'(1);
            if (accept)
                stb_nx = 1'b1;
            else if (issue)
                stb_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en        <= 1'b0;
            outstanding   <= '0;
            bus.wb_cyc_o  <= 1'b0;
            bus.wb_stb_o  <= 1'b0;
            bus.wb_we_o   <= 1'b0;
            bus.wb_adr_o  <= '0;
            bus.wb_dat_o  <= '0;
            bus.wb_sel_o  <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_write <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            rdy_en       <= 1'b1;
            outstanding  <= outstanding_nx;
            bus.wb_stb_o <= stb_nx;
            bus.wb_cyc_o <= stb_nx | (outstanding_nx != '0);
            // Payload only moves on accept, so it holds through any stall.
            if (accept) begin
                bus.wb_we_o  <= bus.req_write;
                bus.wb_adr_o <= bus.req_addr;
                bus.wb_dat_o <= bus.req_wdata;
                bus.wb_sel_o <= bus.req_byteenable;
            end
            bus.rsp_valid <= ack_cnt | abort;
            bus.rsp_write <= bus.wb_we_o;
            bus.rsp_rdata <= (ack_cnt && !bus.wb_we_o) ? bus.wb_dat_i : '0;
        end
    end
endmodule

// File: tb/tb_wb_pipe_master.sv
// Scoreboard bench for wb_pipe_master: directed requests push expected beats/responses,
// a negedge monitor pops and compares, and a scripted Wishbone slave answers with programmable delay.
module tb_wb_pipe_master;
    localparam int AW   = 24;
    localparam int DW   = 16;
    localparam int SW   = DW / 8;
    localparam int MAXO = 4;
`ifdef WB_TIMEOUT_EN
    localparam int TMO  = 16;
`else
    localparam int TMO  = 255;
`endif

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
    } beat_t;

    typedef struct {
        logic          wr;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            acc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_pipe_if #(.AW(AW), .DW(DW)) bus ();

    wb_pipe_master #(
        .AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    beat_t exp_beat[$];
    rsp_t  exp_rsp[$];
    beat_t pend[$];
    int    pend_due[$];
    logic [DW-1:0] mem [int];

    int cyc_n        = 0;
    int ack_delay    = 1;
    int ack_budget   = -1;
    bit spur_req     = 1'b0;
    int stall_beat   = -1;
    int stall_done   = 0;
    int beats_issued = 0;
    int last_ack_cyc = -1;
    int last_acc_cyc = -1;
    int rsp_seen     = 0;
    int cyc_viol     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wishbone slave: drives ACK/data/STALL just after each rising edge.
    initial begin
        beat_t b;
        bus.wb_ack_i   = 1'b0;
        bus.wb_dat_i   = '0;
        bus.wb_stall_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = '0;
            bus.wb_stall_i = 1'b0;
            if (rst_n) begin
                if (pend.size() > 0 && pend_due[0] <= cyc_n && ack_budget != 0) begin
                    b = pend.pop_front();
                    void'(pend_due.pop_front());
                    if (ack_budget > 0) ack_budget--;
                    bus.wb_ack_i = 1'b1;
                    last_ack_cyc = cyc_n;
                    if (b.we) begin
                        if (!mem.exists(int'(b.adr))) mem[int'(b.adr)] = '0;
                        for (int k = 0; k < SW; k++)
                            if (b.sel[k]) mem[int'(b.adr)][k*8 +: 8] = b.dat[k*8 +: 8];
                        bus.wb_dat_i = 16'hDEAD;
                    end else begin
                        bus.wb_dat_i = mem.exists(int'(b.adr)) ? mem[int'(b.adr)] : '0;
                    end
                end else if (spur_req) begin
                    bus.wb_ack_i = 1'b1;
                    bus.wb_dat_i = 16'h5A5A;
                    spur_req = 1'b0;
                end
                if (bus.wb_stb_o && beats_issued == stall_beat && stall_done < 2) begin
                    bus.wb_stall_i = 1'b1;
                    stall_done++;
                end
            end
        end
    end

    // Monitor: beat order/payload, CYC coverage of in-flight beats, response scoreboard.
    always @(negedge clk) begin
        beat_t cur;
        rsp_t  e;
        if (rst_n) begin
            cur = '{we: bus.wb_we_o, adr: bus.wb_adr_o, dat: bus.wb_dat_o, sel: bus.wb_sel_o};
            if (bus.wb_stb_o && !bus.wb_stall_i) begin
                if (exp_beat.size() == 0) check("unexpected_beat", 64'(cur), 64'(0));
                else check("beat_payload", 64'(cur), 64'(exp_beat.pop_front()));
                beats_issued++;
                pend.push_back(cur);
                pend_due.push_back(cyc_n + ack_delay);
            end else if (bus.wb_stb_o && exp_beat.size() > 0) begin
                check("stall_hold", 64'(cur), 64'(exp_beat[0]));
            end
            if ((bus.wb_stb_o || pend.size() > 0) && !bus.wb_cyc_o) cyc_viol++;
            if (bus.rsp_valid) begin
                rsp_seen++;
                if (exp_rsp.size() == 0) begin
                    check("unexpected_rsp", 64'(bus.rsp_rdata), 64'(0));
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_write", 64'(bus.rsp_write), 64'(e.wr));
                    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                    check("rsp_err",   64'(bus.rsp_err),   64'(e.err));
                    if (e.lat > 0) begin
                        check("rsp_latency", 64'(cyc_n - e.acc), 64'(e.lat));
                        check("cyc_low_after_ack", 64'(bus.wb_cyc_o), 64'(0));
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns there with req_valid dropped.
    task automatic send(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] sel, input logic [DW-1:0] exp_rd, input int lat,
                        input logic exp_err, input int max_wait, output bit acc);
        rsp_t r;
        bus.req_valid      = 1'b1;
        bus.req_write      = we;
        bus.req_addr       = adr;
        bus.req_wdata      = wd;
        bus.req_byteenable = sel;
        acc = 1'b0;
        for (int i = 0; i < max_wait && !acc; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc = 1'b1;
                last_acc_cyc = cyc_n;
                exp_beat.push_back('{we: we, adr: adr, dat: wd, sel: sel});
                r.wr = we; r.rdata = we ? '0 : exp_rd; r.err = exp_err; r.lat = lat; r.acc = cyc_n;
                exp_rsp.push_back(r);
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic do_send(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                           input logic [SW-1:0] sel, input logic [DW-1:0] exp_rd, input int lat,
                           input logic exp_err);
        bit acc;
        send(we, adr, wd, sel, exp_rd, lat, exp_err, 200, acc);
        check("request_accepted", 64'(acc), 64'(1));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_rsp.size() > 0 || pend.size() > 0 || bus.wb_cyc_o) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 64'(exp_rsp.size() + pend.size()), 64'(0));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        bit acc;
        int base;
        int seen;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_byteenable = '0;
        for (int i = 0; i < 4; i++) mem[32'h20 + i] = 16'(16'h1111 * (i + 1));
        for (int i = 0; i < 6; i++) mem[32'h40 + i] = 16'(16'hC000 + i);
        mem[32'h30] = 16'hAAAA;

        #12;
        check("rst_cyc",   64'(bus.wb_cyc_o),  64'(0));
        check("rst_stb",   64'(bus.wb_stb_o),  64'(0));
        check("rst_we",    64'(bus.wb_we_o),   64'(0));
        check("rst_adr",   64'(bus.wb_adr_o),  64'(0));
        check("rst_dat",   64'(bus.wb_dat_o),  64'(0));
        check("rst_sel",   64'(bus.wb_sel_o),  64'(0));
        check("rst_rsp",   64'(bus.rsp_valid), 64'(0));
        check("rst_ready", 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write then single read of the same word.
        base = beats_issued; cyc_viol = 0;
        do_send(1'b1, 24'h000010, 16'hBEEF, 2'b11, 16'h0000, 3, 1'b0);
        wait_idle("write_drain");
        check("write_beats", 64'(beats_issued - base), 64'(1));
        base = beats_issued;
        do_send(1'b0, 24'h000010, 16'h0000, 2'b11, 16'hBEEF, 3, 1'b0);
        wait_idle("read_drain");
        check("read_beats", 64'(beats_issued - base), 64'(1));
        check("single_cyc_cont", 64'(cyc_viol), 64'(0));

        // Back-to-back reads with the second beat stalled for two cycles.
        base = beats_issued; cyc_viol = 0; stall_done = 0; stall_beat = beats_issued + 1;
        for (int i = 0; i < 4; i++)
            do_send(1'b0, 24'(32'h20 + i), 16'h0000, 2'b11, 16'(16'h1111 * (i + 1)), 0, 1'b0);
        wait_idle("burst_drain");
        check("burst_beats", 64'(beats_issued - base), 64'(4));
        check("burst_stalled", 64'(stall_done), 64'(2));
        check("burst_cyc_cont", 64'(cyc_viol), 64'(0));
        stall_beat = -1;

        // Partial byte write merges into the slave word.
        do_send(1'b1, 24'h000030, 16'h1234, 2'b01, 16'h0000, 0, 1'b0);
        do_send(1'b0, 24'h000030, 16'h0000, 2'b11, 16'hAA34, 0, 1'b0);
        wait_idle("bytesel_drain");

        // Outstanding limit with ACKs withheld.
        base = beats_issued; ack_budget = 0;
        for (int i = 0; i < 4; i++)
            do_send(1'b0, 24'(32'h40 + i), 16'h0000, 2'b11, 16'(16'hC000 + i), 0, 1'b0);
        send(1'b0, 24'h000044, 16'h0000, 2'b11, 16'hC004, 0, 1'b0, 8, acc);
        check("limit_blocks_5th", 64'(acc), 64'(0));
        ack_budget = 1;
        send(1'b0, 24'h000044, 16'h0000, 2'b11, 16'hC004, 0, 1'b0, 20, acc);
        check("limit_one_after_ack", 64'(acc), 64'(1));
        send(1'b0, 24'h000045, 16'h0000, 2'b11, 16'hC005, 0, 1'b0, 8, acc);
        check("limit_blocks_again", 64'(acc), 64'(0));
        ack_budget = -1;
        wait_idle("limit_drain");
        check("limit_beats", 64'(beats_issued - base), 64'(5));

        // Direction switch waits for the delayed write ACK.
        ack_delay = 5;
        do_send(1'b1, 24'h000050, 16'h7777, 2'b11, 16'h0000, 0, 1'b0);
        do_send(1'b0, 24'h000050, 16'h0000, 2'b11, 16'h7777, 0, 1'b0);
        check("dir_switch_after_ack", 64'(last_acc_cyc - last_ack_cyc), 64'(1));
        ack_delay = 1;
        wait_idle("dir_drain");

        // Spurious ACK while idle.
        seen = rsp_seen;
        spur_req = 1'b1;
        idle_cycles(5);
        check("spurious_no_rsp", 64'(rsp_seen - seen), 64'(0));
        check("spurious_cyc_low", 64'(bus.wb_cyc_o), 64'(0));
        do_send(1'b0, 24'h000010, 16'h0000, 2'b11, 16'hBEEF, 3, 1'b0);
        wait_idle("post_spurious_drain");

`ifdef WB_TIMEOUT_EN
        // Read with no ACK aborts; the late ACK is ignored.
        ack_budget = 0;
        do_send(1'b0, 24'h000060, 16'h0000, 2'b11, 16'h0000, 0, 1'b1);
        for (int n = 0; n < 60 && exp_rsp.size() > 0; n++) idle_cycles(1);
        check("timeout_rsp", 64'(exp_rsp.size()), 64'(0));
        check("timeout_cyc_low", 64'(bus.wb_cyc_o), 64'(0));
        seen = rsp_seen;
        ack_budget = 1;
        idle_cycles(5);
        check("late_ack_ignored", 64'(rsp_seen - seen), 64'(0));
        check("late_ack_cyc_low", 64'(bus.wb_cyc_o), 64'(0));
        ack_budget = -1;
        do_send(1'b0, 24'h000010, 16'h0000, 2'b11, 16'hBEEF, 3, 1'b0);
        wait_idle("post_timeout_drain");
`endif

        // Asynchronous reset mid-cycle drops CYC/STB without waiting for an edge.
        ack_budget = 0;
        do_send(1'b0, 24'h000070, 16'h0000, 2'b11, 16'h0000, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cyc", 64'(bus.wb_cyc_o), 64'(0));
        check("async_rst_stb", 64'(bus.wb_stb_o), 64'(0));
        exp_rsp.delete(); exp_beat.delete(); pend.delete(); pend_due.delete();
        ack_budget = -1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_send(1'b0, 24'h000010, 16'h0000, 2'b11, 16'hBEEF, 3, 1'b0);
        wait_idle("post_reset_drain");
        check("beats_all_issued", 64'(exp_beat.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_pipe_master.md
Name: wb_pipe_master

Overview:
- Wishbone B4 pipelined bus master (initiator) that drives the same bus a Wishbone SDRAM slave responds to.
- Converts a generic valid/ready request port (write, addr, wdata, byteenable) into pipelined STB beats and returns one response per ACK.
- Tracks outstanding transactions so the Wishbone cycle stays open until every beat is acknowledged.
- Used by DMA engines and test masters that feed the SDRAM controller.

Parameters:
AW, 24, bus address width
DW, 16, bus data width; multiple of 8
MAX_OUTSTANDING, 4, maximum STB beats issued but not yet ACKed; must be >= 1
TIMEOUT, 255, cycles without ACK before abort (used only with WB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  AW  request address
req_wdata  in  DW  write data
req_byteenable  in  DW/8  byte enables
rsp_valid  out  1  one-cycle response pulse
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DW  read data; 0 for writes
rsp_err  out  1  response is a timeout abort
wb_cyc_o  out  1  Wishbone CYC
wb_stb_o  out  1  Wishbone STB
wb_we_o  out  1  Wishbone WE
wb_adr_o  out  AW  Wishbone address
wb_dat_o  out  DW  Wishbone write data
wb_sel_o  out  DW/8  Wishbone byte select
wb_dat_i  in  DW  Wishbone read data
wb_ack_i  in  1  Wishbone ACK
wb_stall_i  in  1  Wishbone STALL

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, outstanding count 0. Asserting reset mid-cycle drops CYC/STB immediately. In-flight beats are discarded with no response.
- Issue:
  - An accepted request loads wb_we_o, wb_adr_o, wb_dat_o and wb_sel_o, and sets wb_stb_o on the next edge.
  - A beat is issued on any cycle with wb_stb_o & ~wb_stall_i.
  - STB clears after issue unless a new request is accepted in the same cycle, which allows back-to-back beats.
  - While stalled, STB and all payload registers hold.
- req_ready = (~wb_stb_o | ~wb_stall_i) & (outstanding + wb_stb_o < MAX_OUTSTANDING) & dir_ok.
  - dir_ok = (outstanding == 0 & ~wb_stb_o) | (req_write == wb_we_o).
  - A direction change waits for the bus to drain.
  - ACKs arriving in the same cycle do not raise req_ready (conservative).
- Outstanding counter:
  - Width $clog2(MAX_OUTSTANDING+1).
  - +1 on issue, -1 on wb_ack_i; issue and ACK in the same cycle leaves it unchanged.
  - An ACK while the count is 0 (spurious) is ignored: count stays 0 and no response is generated.
- wb_cyc_o = registered (wb_stb_o next | outstanding next != 0). It deasserts the cycle after the final ACK when no new request is accepted.
- Response:
  - On a counted ACK, the next cycle gives rsp_valid=1, rsp_write=wb_we_o, rsp_rdata = wb_dat_i (reads) or 0 (writes), rsp_err=0.
  - No backpressure on the response port.
  - Responses are in issue order, one per beat.
- Latency: request accepted at edge N -> STB high in cycle N+1 -> earliest ACK in cycle N+2 (registered slave) -> rsp_valid in cycle N+3.

Optional Feature:
- WB_TIMEOUT_EN defined:
  - Watchdog counter clears on any ACK or when outstanding == 0, and increments otherwise.
  - When it reaches TIMEOUT: wb_cyc_o and wb_stb_o are forced to 0 for at least one cycle, outstanding clears, and one rsp_valid pulse is emitted with rsp_err=1, rsp_rdata=0, rsp_write=wb_we_o.
  - req_ready is 0 during the abort cycle.
  - Late ACKs after the abort are treated as spurious.
- Not defined: no watchdog, rsp_err tied 0, the master waits indefinitely for ACK.

Test Plan:
- Single write: req addr 0x000010, wdata 0xBEEF, sel 2'b11, slave ACK 1 cycle after STB -> one STB beat, CYC drops after the ACK, rsp_valid with rsp_write=1 at accept+3.
- Single read: addr 0x000010, slave returns 0xBEEF -> rsp_rdata=0xBEEF, rsp_write=0, CYC high continuously from STB to the ACK.
- Pipelined reads: 4 back-to-back reads (addr 0x20..0x23), wb_stall_i high for the 2nd beat's first 2 cycles -> 4 issued beats in order with payload held during stall, 4 responses in order, CYC never drops mid-burst.
- Outstanding limit: MAX_OUTSTANDING=4, slave withholds ACK -> req_ready low after 4 issues; one ACK -> exactly one further request accepted.
- Direction switch: write then read with the write ACK delayed 5 cycles -> read not accepted until the write ACK is received and STB is low; spurious ACK while idle -> no rsp_valid.
- WB_TIMEOUT_EN, TIMEOUT=16: read with no ACK -> at cycle 16 without ACK, CYC drops, one rsp_valid with rsp_err=1 and rsp_rdata=0; a later ACK is ignored.
